// File: rtl/kernel_fdtd_2d_udiv_seq_if.sv
// Operand/result handshake bundle for kernel_fdtd_2d_udiv_seq.
//
// Signals:
//   in_vld / in_rdy        operand handshake (producer -> divider)
//   dividend, divisor      unsigned operands, held by the producer until accepted
//   out_vld / out_rdy      result handshake (divider -> consumer)
//   quotient, remainder    registered unsigned results
//   dbz                    divide-by-zero flag, only with KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
//
// Modports: slave = divider side, master = producer/consumer side.
interface kernel_fdtd_2d_udiv_seq_if #(
    parameter int unsigned DIVIDEND_W = 20,
    parameter int unsigned DIVISOR_W  = 11
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
    logic                  dbz;
`endif

    modport slave (
        input  in_vld, dividend, divisor, out_rdy,
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
        output dbz,
`endif
        output in_rdy, out_vld, quotient, remainder
    );

    modport master (
        output in_vld, dividend, divisor, out_rdy,
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
        input  dbz,
`endif
        input  in_rdy, out_vld, quotient, remainder
    );
endinterface

// File: rtl/kernel_fdtd_2d_udiv_seq.sv
// Sequential unsigned radix-2 restoring divider (one bit per enabled cycle).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   ce       clock enable; with ce=0 every register (state, counter, results) holds
//   bus      kernel_fdtd_2d_udiv_seq_if.slave: operand and result valid/ready handshakes
//
// Timing with ce held high: accept at edge T, quotient/remainder valid after edge T+N+1
// (N iterations, then one write-back cycle); divisor 0 goes straight to DONE.
// Divide-by-zero returns an all-ones quotient and remainder = dividend[M-1:0].
//
// Optional macro KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN adds a registered dbz result flag.
module kernel_fdtd_2d_udiv_seq #(
    parameter int unsigned ID         = 1,
    parameter int unsigned DIVIDEND_W = 20,
    parameter int unsigned DIVISOR_W  = 11
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      ce,
    kernel_fdtd_2d_udiv_seq_if.slave bus
);
    localparam int unsigned N    = DIVIDEND_W;
    localparam int unsigned M    = DIVISOR_W;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [M:0]      rem_q, rem_d;    // partial remainder, one guard bit
    logic [N-1:0]    sh_q, sh_d;      // dividend shifts out, quotient bits shift in
    logic [M-1:0]    dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;  // all N iterations done, write back next cycle
    logic [N-1:0]    quo_q, quo_d;
    logic [M-1:0]    rmd_q, rmd_d;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
    logic            dbz_q, dbz_d;
`endif

    // One restoring step on {rem, q} shifted left by one.
    logic [M+1:0] shifted;
    logic         geq;
    logic [M:0]   diff;

    assign shifted = {rem_q, sh_q[N-1]};
    assign geq     = shifted >= {2'b00, dvs_q};
    // shifted < 2*divisor here, so the difference always fits in M+1 bits.
    assign diff    = shifted[M:0] - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_vld) begin
                    dvs_d  = bus.divisor;
                    sh_d   = bus.dividend;
                    rem_d  = '0;
                    last_d = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = StDone;
                        quo_d   = '1;
                        rmd_d   = bus.dividend[M-1:0];
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
                        dbz_d   = 1'b1;
`endif
                    end else begin
                        state_d = StCalc;
                        cnt_d   = CntW'(N - 1);
                    end
                end
            end
            StCalc: begin
                if (last_q) begin
                    state_d = StDone;
                    quo_d   = sh_q;
                    rmd_d   = rem_q[M-1:0];
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
                    dbz_d   = 1'b0;
`endif
                end else begin
                    rem_d = geq ? diff : shifted[M:0];
                    sh_d  = {sh_q[N-2:0], geq};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        last_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (bus.out_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else if (ce) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign bus.in_rdy    = (state_q == StIdle);
    assign bus.out_vld   = (state_q == StDone);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
    assign bus.dbz       = dbz_q;
`endif
endmodule

// File: tb/tb_kernel_fdtd_2d_udiv_seq.sv
// Directed bench for kernel_fdtd_2d_udiv_seq: hand-computed quotient/remainder vectors,
// latency, divide-by-zero, backpressure, clock-enable gating and mid-operation reset.
module tb_kernel_fdtd_2d_udiv_seq;
    logic clk;
    logic reset;
    logic ce;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    kernel_fdtd_2d_udiv_seq_if #(.DIVIDEND_W(20), .DIVISOR_W(11)) bus_if ();

    kernel_fdtd_2d_udiv_seq #(
        .ID         (1),
        .DIVIDEND_W (20),
        .DIVISOR_W  (11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Called #1 after a posedge; waits (bounded) for in_rdy, then presents operands for
    // one accepting edge with ce=1.
    task automatic send(input logic [19:0] a, input logic [10:0] b);
        for (int k = 0; k < 50 && !bus_if.in_rdy; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("in_rdy_before_send", 32'(bus_if.in_rdy), 32'd1);
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.in_vld   = 1'b1;
        ce              = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_vld   = 1'b0;
    endtask

    // Counts enabled edges after the accept edge until out_vld; -1 on timeout.
    task automatic wait_result(input bit toggle_ce, output int n_en);
        n_en = 0;
        for (int k = 0; k < 200 && !bus_if.out_vld; k++) begin
            if (toggle_ce) ce = ~ce;
            @(posedge clk);
            if (ce) n_en++;
            #1;
        end
        ce = 1'b1;
        if (!bus_if.out_vld) n_en = -1;
    endtask

    task automatic run_div(input string tag, input logic [19:0] a, input logic [10:0] b,
                           input logic [19:0] exp_q, input logic [10:0] exp_r,
                           input int exp_lat, input bit toggle_ce);
        int n;
        send(a, b);
        wait_result(toggle_ce, n);
        check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_quotient"}, 32'(bus_if.quotient), 32'(exp_q));
        check_eq({tag, "_remainder"}, 32'(bus_if.remainder), 32'(exp_r));
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
        check_eq({tag, "_dbz"}, 32'(bus_if.dbz), (b == 11'd0) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        reset          = 1'b0;
        ce             = 1'b1;
        bus_if.in_vld  = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor = '0;
        bus_if.out_rdy = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_in_rdy", 32'(bus_if.in_rdy), 32'd1);
        check_eq("reset_out_vld", 32'(bus_if.out_vld), 32'd0);
        check_eq("reset_quotient", 32'(bus_if.quotient), 32'd0);
        check_eq("reset_remainder", 32'(bus_if.remainder), 32'd0);
`ifdef KERNEL_FDTD_2D_UDIV_SEQ_DBZ_FLAG_EN
        check_eq("reset_dbz", 32'(bus_if.dbz), 32'd0);
`endif
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Main vectors, consumer always ready.
        run_div("d1000000_7", 20'd1000000, 11'd7, 20'd142857, 11'd1, 21, 1'b0);
        @(posedge clk); #1;
        check_eq("in_rdy_after_consume", 32'(bus_if.in_rdy), 32'd1);
        run_div("d1048575_2047", 20'd1048575, 11'd2047, 20'd512, 11'd511, 21, 1'b0);
        @(posedge clk); #1;
        run_div("d5_9", 20'd5, 11'd9, 20'd0, 11'd5, 21, 1'b0);
        @(posedge clk); #1;

        // Divide by zero: result in the cycle right after the accept edge.
        run_div("dbz_12345", 20'd12345, 11'd0, 20'hFFFFF, 11'd57, 0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: results held, operands offered while busy are ignored.
        bus_if.out_rdy = 1'b0;
        run_div("bp", 20'd1000000, 11'd7, 20'd142857, 11'd1, 21, 1'b0);
        bus_if.dividend = 20'd99;
        bus_if.divisor  = 11'd4;
        bus_if.in_vld   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_out_vld", 32'(bus_if.out_vld), 32'd1);
            check_eq("bp_in_rdy", 32'(bus_if.in_rdy), 32'd0);
            check_eq("bp_quotient", 32'(bus_if.quotient), 32'd142857);
            check_eq("bp_remainder", 32'(bus_if.remainder), 32'd1);
        end
        bus_if.in_vld = 1'b0;
        // Ready but disabled: handshake must not complete.
        bus_if.out_rdy = 1'b1;
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("ce0_done_hold", 32'(bus_if.out_vld), 32'd1);
        ce = 1'b1;
        check_eq("handshake_in_rdy", 32'(bus_if.in_rdy), 32'd0);
        @(posedge clk); #1;
        check_eq("consumed_out_vld", 32'(bus_if.out_vld), 32'd0);
        check_eq("consumed_in_rdy", 32'(bus_if.in_rdy), 32'd1);
        check_eq("consumed_quotient_hold", 32'(bus_if.quotient), 32'd142857);

        // Clock enable alternating each cycle: same result after 21 enabled edges.
        run_div("ce_toggle", 20'd1000000, 11'd7, 20'd142857, 11'd1, 21, 1'b1);
        @(posedge clk); #1;

        // Reset during CALC aborts the division.
        send(20'd1000000, 11'd7);
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_out_vld", 32'(bus_if.out_vld), 32'd0);
        check_eq("abort_in_rdy", 32'(bus_if.in_rdy), 32'd1);
        check_eq("abort_quotient", 32'(bus_if.quotient), 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_no_result", 32'(bus_if.out_vld), 32'd0);
        run_div("d100_3", 20'd100, 11'd3, 20'd33, 11'd1, 21, 1'b0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
